// File: rtl/wb_arb2_if.sv
// Bus bundle for the two-master Wishbone arbiter: both master request/response
// buses plus the shared slave bus.
interface wb_arb2_if;
  logic [15:0] m0_adr_i, m1_adr_i;
  logic [15:0] m0_dat_i, m1_dat_i;
  logic [1:0]  m0_sel_i, m1_sel_i;
  logic        m0_we_i, m1_we_i;
  logic        m0_cyc_i, m1_cyc_i;
  logic        m0_stb_i, m1_stb_i;
  logic [15:0] m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m1_ack_o;
  logic        m0_err_o, m1_err_o;
  logic [15:0] s_adr_o, s_dat_o;
  logic [1:0]  s_sel_o;
  logic        s_we_o, s_cyc_o, s_stb_o;
  logic [15:0] s_dat_i;
  logic        s_ack_i;

  // Arbiter side: it masters the shared slave bus.
  modport master (
    input  m0_adr_i, m0_dat_i, m0_sel_i, m0_we_i, m0_cyc_i, m0_stb_i,
    input  m1_adr_i, m1_dat_i, m1_sel_i, m1_we_i, m1_cyc_i, m1_stb_i,
    output m0_dat_o, m0_ack_o, m0_err_o, m1_dat_o, m1_ack_o, m1_err_o,
    output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
    input  s_dat_i, s_ack_i
  );

  // Environment side: requesting masters and the decoded slave.
  modport slave (
    output m0_adr_i, m0_dat_i, m0_sel_i, m0_we_i, m0_cyc_i, m0_stb_i,
    output m1_adr_i, m1_dat_i, m1_sel_i, m1_we_i, m1_cyc_i, m1_stb_i,
    input  m0_dat_o, m0_ack_o, m0_err_o, m1_dat_o, m1_ack_o, m1_err_o,
    input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
    output s_dat_i, s_ack_i
  );
endinterface

// File: rtl/wb_arb2.sv
// Two-master round-robin Wishbone arbiter with whole-cycle bus lock, a forced
// IDLE turnaround between owners, and an ack timeout that reports err.
module wb_arb2 #(
  parameter int unsigned TMO  = 15,
  parameter int unsigned TMOW = 4
) (
  input  logic       clk,
  input  logic       reset,
  wb_arb2_if.master  bus,
  output logic [1:0] gnt
);

  typedef enum logic [1:0] {StIdle = 2'b00, StOwn0 = 2'b01, StOwn1 = 2'b10} state_e;

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic [TMOW-1:0]   cnt_q, cnt_d;
  logic              tmo_hit;

  assign gnt = state_q;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (bus.m0_cyc_i && bus.m1_cyc_i) begin
          state_d = last_q ? StOwn0 : StOwn1;
        end else if (bus.m0_cyc_i) begin
          state_d = StOwn0;
        end else if (bus.m1_cyc_i) begin
          state_d = StOwn1;
        end
        if (state_d == StOwn0) last_d = 1'b0;
        if (state_d == StOwn1) last_d = 1'b1;
      end
      StOwn0:  if (!bus.m0_cyc_i) state_d = StIdle;
      StOwn1:  if (!bus.m1_cyc_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.s_adr_o = '0;
    bus.s_dat_o = '0;
    bus.s_sel_o = '0;
    bus.s_we_o  = 1'b0;
    bus.s_cyc_o = 1'b0;
    bus.s_stb_o = 1'b0;
    unique case (state_q)
      StOwn0: begin
        bus.s_adr_o = bus.m0_adr_i;
        bus.s_dat_o = bus.m0_dat_i;
        bus.s_sel_o = bus.m0_sel_i;
        bus.s_we_o  = bus.m0_we_i;
        bus.s_cyc_o = bus.m0_cyc_i;
        bus.s_stb_o = bus.m0_stb_i;
      end
      StOwn1: begin
        bus.s_adr_o = bus.m1_adr_i;
        bus.s_dat_o = bus.m1_dat_i;
        bus.s_sel_o = bus.m1_sel_i;
        bus.s_we_o  = bus.m1_we_i;
        bus.s_cyc_o = bus.m1_cyc_i;
        bus.s_stb_o = bus.m1_stb_i;
      end
      default: ;
    endcase
  end

  // Err fires in the cycle the counter would reach TMO, so the TMO-th strobe
  // cycle without ack reports; a same-cycle ack suppresses it.
  assign tmo_hit = (state_q != StIdle) && bus.s_stb_o && !bus.s_ack_i &&
                   (cnt_q == TMOW'(TMO - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (state_q == StIdle || bus.s_ack_i || !bus.s_stb_o || tmo_hit) cnt_d = '0;
  end

  assign bus.m0_ack_o = bus.s_ack_i & gnt[0] & bus.m0_stb_i;
  assign bus.m1_ack_o = bus.s_ack_i & gnt[1] & bus.m1_stb_i;
  assign bus.m0_dat_o = gnt[0] ? bus.s_dat_i : 16'h0000;
  assign bus.m1_dat_o = gnt[1] ? bus.s_dat_i : 16'h0000;
  assign bus.m0_err_o = tmo_hit & gnt[0];
  assign bus.m1_err_o = tmo_hit & gnt[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_arb2.sv
// Directed bench for wb_arb2: reset, tie-break, round-robin, read data path,
// ack timeout, bus lock and asynchronous reset abort.
module tb_wb_arb2;
  logic       clk;
  logic       reset;
  logic [1:0] gnt;
  int         n_checks;
  int         n_fail;

  wb_arb2_if bus ();

  wb_arb2 #(.TMO(15), .TMOW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .gnt   (gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic owner;
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b0;
    bus.m0_adr_i = 16'hA000; bus.m0_dat_i = 16'h0AAA; bus.m0_sel_i = 2'b11;
    bus.m0_we_i  = 1'b1;     bus.m0_cyc_i = 1'b0;     bus.m0_stb_i = 1'b0;
    bus.m1_adr_i = 16'hB800; bus.m1_dat_i = 16'h0BBB; bus.m1_sel_i = 2'b01;
    bus.m1_we_i  = 1'b0;     bus.m1_cyc_i = 1'b0;     bus.m1_stb_i = 1'b0;
    bus.s_dat_i  = 16'h0000; bus.s_ack_i  = 1'b0;

    // Reset state
    #12;
    check_eq("rst_gnt", 32'(gnt), 32'h0);
    check_eq("rst_stb", 32'(bus.s_stb_o), 32'h0);
    check_eq("rst_cyc", 32'(bus.s_cyc_o), 32'h0);
    check_eq("rst_err", 32'({bus.m0_err_o, bus.m1_err_o}), 32'h0);

    // Tie straight out of reset goes to m0
    reset = 1'b1;
    bus.m0_cyc_i = 1'b1; bus.m0_stb_i = 1'b1;
    bus.m1_cyc_i = 1'b1; bus.m1_stb_i = 1'b1;
    tick();
    check_eq("tie_gnt", 32'(gnt), 32'h1);
    check_eq("tie_adr", 32'(bus.s_adr_o), 32'hA000);
    check_eq("tie_we", 32'(bus.s_we_o), 32'h1);
    bus.m0_cyc_i = 1'b0; bus.m0_stb_i = 1'b0;
    tick();
    check_eq("turn_gnt", 32'(gnt), 32'h0);
    check_eq("turn_adr", 32'(bus.s_adr_o), 32'h0);
    tick();
    check_eq("m1_gnt", 32'(gnt), 32'h2);
    check_eq("m1_adr", 32'(bus.s_adr_o), 32'hB800);
    check_eq("m1_sel", 32'(bus.s_sel_o), 32'h1);

    // Read by m1, slave ack two cycles after stb; m0 requests meanwhile
    bus.m0_cyc_i = 1'b1; bus.m0_stb_i = 1'b1;
    tick();
    check_eq("rd_wait_ack", 32'(bus.m1_ack_o), 32'h0);
    tick();
    bus.s_ack_i = 1'b1; bus.s_dat_i = 16'h1234;
    #1;
    check_eq("rd_m1_ack", 32'(bus.m1_ack_o), 32'h1);
    check_eq("rd_m1_dat", 32'(bus.m1_dat_o), 32'h1234);
    check_eq("rd_m0_ack", 32'(bus.m0_ack_o), 32'h0);
    check_eq("rd_m0_dat", 32'(bus.m0_dat_o), 32'h0);
    bus.s_ack_i = 1'b0;
    bus.m1_cyc_i = 1'b0; bus.m1_stb_i = 1'b0;
    bus.m0_cyc_i = 1'b0;
    tick();
    check_eq("rd_idle", 32'(gnt), 32'h0);

    // Stray ack while idle is ignored
    bus.s_ack_i = 1'b1;
    #1;
    check_eq("idle_ack0", 32'(bus.m0_ack_o), 32'h0);
    check_eq("idle_ack1", 32'(bus.m1_ack_o), 32'h0);
    tick();
    check_eq("idle_hold", 32'(gnt), 32'h0);
    bus.s_ack_i = 1'b0;

    // Timeout: err on the 15th unacked strobe cycle only
    bus.m0_cyc_i = 1'b1;
    tick();
    check_eq("tmo_gnt", 32'(gnt), 32'h1);
    for (int k = 1; k <= 15; k++) begin
      check_eq($sformatf("tmo_err_c%0d", k), 32'(bus.m0_err_o), 32'(k == 15));
      if (k == 15) begin
        check_eq("tmo_noack", 32'(bus.m0_ack_o), 32'h0);
        check_eq("tmo_m1err", 32'(bus.m1_err_o), 32'h0);
      end
      tick();
    end
    check_eq("tmo_keep_gnt", 32'(gnt), 32'h1);
    // Ack on the 15th cycle beats the timeout
    for (int k = 1; k <= 15; k++) begin
      if (k == 15) begin
        bus.s_ack_i = 1'b1;
        #1;
        check_eq("tmo_ack_win", 32'(bus.m0_ack_o), 32'h1);
        check_eq("tmo_ack_noerr", 32'(bus.m0_err_o), 32'h0);
      end else begin
        check_eq($sformatf("tmo2_err_c%0d", k), 32'(bus.m0_err_o), 32'h0);
        tick();
      end
    end
    bus.s_ack_i = 1'b0;

    // Lock: m0 keeps cyc across three strobes while m1 waits
    bus.m1_cyc_i = 1'b1; bus.m1_stb_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.m0_stb_i = 1'b0;
      tick();
      check_eq($sformatf("lock_lo%0d", i), 32'(gnt), 32'h1);
      bus.m0_stb_i = 1'b1;
      tick();
      check_eq($sformatf("lock_hi%0d", i), 32'(gnt), 32'h1);
    end
    // Drop cyc mid-transfer: bus released next cycle
    bus.m0_cyc_i = 1'b0;
    tick();
    check_eq("drop_gnt", 32'(gnt), 32'h0);
    check_eq("drop_stb", 32'(bus.s_stb_o), 32'h0);
    tick();
    check_eq("drop_m1", 32'(gnt), 32'h2);

    // Round-robin with both masters requesting single transfers
    bus.m0_cyc_i = 1'b1; bus.m0_stb_i = 1'b1;
    owner = 1'b1;
    for (int r = 0; r < 4; r++) begin
      bus.s_ack_i = 1'b1;
      #1;
      check_eq($sformatf("rr_ack%0d", r),
               32'(owner ? bus.m1_ack_o : bus.m0_ack_o), 32'h1);
      bus.s_ack_i = 1'b0;
      if (owner) bus.m1_cyc_i = 1'b0; else bus.m0_cyc_i = 1'b0;
      tick();
      check_eq($sformatf("rr_idle%0d", r), 32'(gnt), 32'h0);
      if (owner) bus.m1_cyc_i = 1'b1; else bus.m0_cyc_i = 1'b1;
      tick();
      owner = ~owner;
      check_eq($sformatf("rr_gnt%0d", r), 32'(gnt), owner ? 32'h2 : 32'h1);
    end

    // Async reset mid-OWN1 transfer
    bus.s_ack_i = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check_eq("arst_gnt", 32'(gnt), 32'h0);
    check_eq("arst_stb", 32'(bus.s_stb_o), 32'h0);
    check_eq("arst_ack", 32'(bus.m1_ack_o), 32'h0);
    check_eq("arst_dat", 32'(bus.m1_dat_o), 32'h0);
    #1;
    reset = 1'b1;
    bus.s_ack_i = 1'b0;
    tick();
    check_eq("arst_tie", 32'(gnt), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_arb2.md
WB_ARB2 -- requirements
Module: wb_arb2

Interface
REQ-001 SHALL have parameter TMO, default 15, meaning ack-timeout in clk cycles (range 2..15).
REQ-002 SHALL have parameter TMOW, default 4, meaning timeout counter width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have, for N=0,1: mN_adr_i input 16, mN_dat_i input 16, mN_sel_i input 2, mN_we_i input 1, mN_cyc_i input 1, mN_stb_i input 1 (master N request bus).
REQ-006 SHALL have, for N=0,1: mN_dat_o output 16, mN_ack_o output 1, mN_err_o output 1 (master N response).
REQ-007 SHALL have s_adr_o output 16, s_dat_o output 16, s_sel_o output 2, s_we_o output 1, s_cyc_o output 1, s_stb_o output 1 (shared slave bus).
REQ-008 SHALL have s_dat_i input 16, s_ack_i input 1 (OR of decoded slave acks and data).
REQ-009 SHALL have gnt output 2, one-hot current owner (00 = idle).

Function
REQ-010 SHALL implement FSM states IDLE, OWN0, OWN1; gnt = 00/01/10 respectively, driven from the state register.
REQ-011 IDLE: m0_cyc_i only -> OWN0; m1_cyc_i only -> OWN1; both -> master not equal to last-served pointer `last`; neither -> stay IDLE.
REQ-012 `last` SHALL update to N on every entry into OWNN.
REQ-013 OWNN SHALL hold while mN_cyc_i=1 (bus lock for whole cycle, incl. read-modify-write); mN_cyc_i=0 -> IDLE.
REQ-014 Handover SHALL always pass through one IDLE cycle (turnaround); minimum grant latency from cyc to gnt = 1 cycle.
REQ-015 In OWNN, s_adr_o/s_dat_o/s_sel_o/s_we_o/s_cyc_o/s_stb_o SHALL combinationally equal master N's signals; in IDLE all SHALL be 0.
REQ-016 mN_ack_o SHALL = s_ack_i & gnt[N] & mN_stb_i; non-granted master ack SHALL be 0.
REQ-017 mN_dat_o SHALL = s_dat_i when gnt[N], else 16'h0000.
REQ-018 Timeout counter SHALL clear in IDLE, on s_ack_i, or when s_stb_o=0; otherwise increment per cycle.
REQ-019 When counter reaches TMO with s_stb_o=1 and s_ack_i=0, SHALL assert mN_err_o for exactly one cycle to owner N and clear counter; mN_ack_o SHALL not assert that cycle.
REQ-020 s_ack_i arriving the same cycle counter reaches TMO SHALL win: ack delivered, no err.
REQ-021 err SHALL NOT release the grant; release only by mN_cyc_i falling.
REQ-022 s_ack_i asserted in IDLE SHALL be ignored (no master ack, no state change).
REQ-023 A master dropping cyc mid-transfer SHALL release the bus next cycle; counter cleared.

Reset
REQ-024 reset=0 SHALL immediately force state IDLE, gnt=00, last=1 (m0 wins first tie), counter=0, all err outputs 0.
REQ-025 While in reset all s_*_o and mN_ack_o/mN_dat_o SHALL be 0; reset mid-transfer aborts with no ack/err issued.
REQ-026 First grant SHALL be possible on the first rising edge after reset deasserts.

Verification
REQ-027 Tie from reset: m0_cyc/m1_cyc both rise cycle 0 -> gnt=01 at cycle 1; m0 drops cyc -> IDLE one cycle -> gnt=10.
REQ-028 Round-robin: both masters continuously requesting single transfers -> gnt sequence 01,00,10,00,01,00,10...
REQ-029 Read: OWN1, m1_adr_i=16'hB800, slave ack 2 cycles after stb with s_dat_i=16'h1234 -> m1_ack_o=1, m1_dat_o=16'h1234, m0_ack_o=0.
REQ-030 Timeout: OWN0, s_ack_i held 0 -> m0_err_o pulses exactly at 15th stb cycle, gnt stays 01; ack on cycle 15 instead -> ack, no err.
REQ-031 Lock: m0 holds cyc across 3 stb pulses while m1 requests -> gnt stays 01 until m0_cyc_i=0.
REQ-032 Async reset asserted mid-OWN1 transfer -> gnt=00, s_stb_o=0 without clk edge; after release m0/m1 tie grants m0.
